// File: rtl/k423_wb_rf_arbiter_pkg.sv
// k423_wb_rf_arbiter_pkg: shared types, widths and defaults for the WB regfile write-port arbiter.
// Falls back to RV32 widths when the core-wide width macros are not defined.
`ifndef INST_RSDIDX_W
`define INST_RSDIDX_W 5
`endif
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
package k423_wb_rf_arbiter_pkg;
    localparam int IDX_W = `INST_RSDIDX_W;
    localparam int XLEN = `CORE_XLEN;
    localparam int QUEUE_DEPTH_DEF = 2;
    localparam int STARVE_MAX_DEF = 4;
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  data;
    } wb_req_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_PIPE, SEL_QUEUE, SEL_BYPASS} wb_sel_e;
    function automatic logic [31:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return 32'(1) << idx;
    endfunction
endpackage

// File: rtl/k423_wb_rf_arbiter_if.sv
// k423_wb_rf_arbiter_if: pipeline WB, LU return and regfile write-port bundle.
// Perf counter outputs exist only with K423_WB_ARB_PERF_EN.
interface k423_wb_rf_arbiter_if;
    import k423_wb_rf_arbiter_pkg::*;
    logic             pipe_rd_vld_i;
    logic [IDX_W-1:0] pipe_rd_idx_i;
    logic [XLEN-1:0]  pipe_rd_data_i;
    logic             pipe_stall_o;
    logic             lu_rd_vld_i;
    logic [IDX_W-1:0] lu_rd_idx_i;
    logic [XLEN-1:0]  lu_rd_data_i;
    logic             lu_rd_rdy_o;
    logic             wb_rd_vld_o;
    logic [IDX_W-1:0] wb_rd_idx_o;
    logic [XLEN-1:0]  wb_rd_data_o;
    logic [31:0]      pend_mask_o;
`ifdef K423_WB_ARB_PERF_EN
    logic [31:0]      perf_conflict_cnt_o;
    logic [31:0]      perf_force_cnt_o;
`endif
    modport slave (
`ifdef K423_WB_ARB_PERF_EN
        output perf_conflict_cnt_o, perf_force_cnt_o,
`endif
        input  pipe_rd_vld_i, pipe_rd_idx_i, pipe_rd_data_i, lu_rd_vld_i, lu_rd_idx_i, lu_rd_data_i,
        output pipe_stall_o, lu_rd_rdy_o, wb_rd_vld_o, wb_rd_idx_o, wb_rd_data_o, pend_mask_o
    );
    modport master (
`ifdef K423_WB_ARB_PERF_EN
        input  perf_conflict_cnt_o, perf_force_cnt_o,
`endif
        output pipe_rd_vld_i, pipe_rd_idx_i, pipe_rd_data_i, lu_rd_vld_i, lu_rd_idx_i, lu_rd_data_i,
        input  pipe_stall_o, lu_rd_rdy_o, wb_rd_vld_o, wb_rd_idx_o, wb_rd_data_o, pend_mask_o
    );
endinterface

// File: rtl/k423_wb_lu_queue.sv
// k423_wb_lu_queue: in-order circular buffer of LU results with pending-register mask.
module k423_wb_lu_queue
    import k423_wb_rf_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enq,
    input  logic [IDX_W-1:0] enq_idx,
    input  logic [XLEN-1:0]  enq_data,
    input  logic             deq,
    output wb_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [31:0]      pend_mask
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   cnt;
    logic [QUEUE_DEPTH-1:0] vld;
    logic [IDX_W-1:0] idx_q [QUEUE_DEPTH];
    logic [XLEN-1:0]  data_q [QUEUE_DEPTH];
    assign empty = cnt == '0;
    assign full = cnt == (PTR_W+1)'(QUEUE_DEPTH);
    assign head = '{vld: !empty, idx: idx_q[rd_ptr], data: data_q[rd_ptr]};
    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
            if (deq) vld[rd_ptr] <= 1'b0;
            if (enq) vld[wr_ptr] <= 1'b1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (enq) begin
            idx_q[wr_ptr] <= enq_idx;
            data_q[wr_ptr] <= enq_data;
        end
    end
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) pend_mask |= vld[i] ? idx_onehot(idx_q[i]) : 32'd0;
    end
endmodule

// File: rtl/k423_wb_rf_arbiter.sv
// k423_wb_rf_arbiter: shares the regfile write port between pipeline WB (priority) and queued LU results.
// Optional perf counters are enabled with K423_WB_ARB_PERF_EN.
module k423_wb_rf_arbiter
    import k423_wb_rf_arbiter_pkg::*;
#(
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int STARVE_MAX  = STARVE_MAX_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    k423_wb_rf_arbiter_if.slave bus
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    wb_req_t         head, sel_req;
    wb_sel_e         sel;
    logic            full, empty, force_wr, enq, deq;
    logic [31:0]     pend_mask;
    logic [SC_W-1:0] starve_cnt;
    k423_wb_lu_queue #(.QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .enq       (enq),
        .enq_idx   (bus.lu_rd_idx_i),
        .enq_data  (bus.lu_rd_data_i),
        .deq       (deq),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .pend_mask (pend_mask)
    );
    assign force_wr = !empty && starve_cnt == SC_W'(STARVE_MAX);
    always_comb begin
        sel = force_wr ? SEL_QUEUE : bus.pipe_rd_vld_i ? SEL_PIPE : !empty ? SEL_QUEUE :
              bus.lu_rd_vld_i ? SEL_BYPASS : SEL_NONE;
        sel_req = sel == SEL_QUEUE  ? head :
                  sel == SEL_PIPE   ? wb_req_t'{1'b1, bus.pipe_rd_idx_i, bus.pipe_rd_data_i} :
                  sel == SEL_BYPASS ? wb_req_t'{1'b1, bus.lu_rd_idx_i, bus.lu_rd_data_i} : wb_req_t'('0);
    end
    assign deq = sel == SEL_QUEUE;
    // x0 results are accepted but never occupy a slot or a pend bit.
    assign enq = bus.lu_rd_vld_i && !full && |bus.lu_rd_idx_i && sel != SEL_BYPASS;
    assign bus.lu_rd_rdy_o = !full;
    assign bus.pipe_stall_o = rst_n_i && force_wr && bus.pipe_rd_vld_i;
    assign bus.wb_rd_vld_o = rst_n_i && sel_req.vld && |sel_req.idx;
    assign bus.wb_rd_idx_o = rst_n_i ? sel_req.idx : '0;
    assign bus.wb_rd_data_o = rst_n_i ? sel_req.data : '0;
    assign bus.pend_mask_o = pend_mask;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) starve_cnt <= '0;
        else starve_cnt <= (empty || deq) ? '0 : starve_cnt + SC_W'(starve_cnt != SC_W'(STARVE_MAX));
    end
`ifdef K423_WB_ARB_PERF_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.perf_conflict_cnt_o <= '0;
            bus.perf_force_cnt_o <= '0;
        end else begin
            bus.perf_conflict_cnt_o <= bus.perf_conflict_cnt_o + 32'(bus.pipe_rd_vld_i && (!empty || bus.lu_rd_vld_i));
            bus.perf_force_cnt_o <= bus.perf_force_cnt_o + 32'(force_wr);
        end
    end
`endif
endmodule

// File: tb/tb_k423_wb_rf_arbiter.sv
// tb_k423_wb_rf_arbiter: directed plus random stimulus against a queue-based reference model.
module tb_k423_wb_rf_arbiter;
    import k423_wb_rf_arbiter_pkg::*;
    localparam int QD = 2;
    localparam int SM = 4;
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [XLEN-1:0]  data;
    } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    k423_wb_rf_arbiter_if bus ();
    k423_wb_rf_arbiter #(.QUEUE_DEPTH(QD), .STARVE_MAX(SM)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );
    ent_t q[$];
    int sc;
    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] rf_exp [32];
    logic [XLEN-1:0] rf_dut [32];
    logic [31:0] conf_exp, frc_exp;
    always @(posedge clk) if (bus.wb_rd_vld_o) rf_dut[bus.wb_rd_idx_o] <= bus.wb_rd_data_o;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [IDX_W-1:0] pi, input logic [XLEN-1:0] pd,
                         input logic lv, input logic [IDX_W-1:0] li, input logic [XLEN-1:0] ld);
        bus.pipe_rd_vld_i = pv;
        bus.pipe_rd_idx_i = pi;
        bus.pipe_rd_data_i = pd;
        bus.lu_rd_vld_i = lv;
        bus.lu_rd_idx_i = li;
        bus.lu_rd_data_i = ld;
    endtask

    // One cycle: drive after the falling edge, check mid-phase, advance the model at the rising edge.
    task automatic step(input logic pv, input logic [IDX_W-1:0] pi, input logic [XLEN-1:0] pd,
                        input logic lv, input logic [IDX_W-1:0] li, input logic [XLEN-1:0] ld);
        bit full, frc, hadq, e_vld, e_stall;
        int e_sel;
        logic [IDX_W-1:0] e_idx;
        logic [XLEN-1:0] e_data;
        logic [31:0] pend;
        drive(pv, pi, pd, lv, li, ld);
        #1;
        full = q.size() == QD;
        frc = q.size() != 0 && sc == SM;
        e_stall = frc && pv;
        e_sel = frc ? 2 : pv ? 1 : q.size() != 0 ? 2 : lv ? 3 : 0;
        e_idx = e_sel == 1 ? pi : e_sel == 3 ? li : e_sel == 2 ? q[0].idx : '0;
        e_data = e_sel == 1 ? pd : e_sel == 3 ? ld : e_sel == 2 ? q[0].data : '0;
        e_vld = e_sel != 0 && e_idx != 0;
        pend = '0;
        foreach (q[i]) pend[q[i].idx] = 1'b1;
        chk("stall", 64'(bus.pipe_stall_o), 64'(e_stall));
        chk("rdy", 64'(bus.lu_rd_rdy_o), 64'(!full));
        chk("wb_vld", 64'(bus.wb_rd_vld_o), 64'(e_vld));
        if (e_vld) begin
            chk("wb_idx", 64'(bus.wb_rd_idx_o), 64'(e_idx));
            chk("wb_data", 64'(bus.wb_rd_data_o), 64'(e_data));
        end
        chk("pend", 64'(bus.pend_mask_o), 64'(pend));
`ifdef K423_WB_ARB_PERF_EN
        chk("perf_conf", 64'(bus.perf_conflict_cnt_o), 64'(conf_exp));
        chk("perf_force", 64'(bus.perf_force_cnt_o), 64'(frc_exp));
`endif
        @(posedge clk);
        hadq = q.size() != 0;
        if (pv && (hadq || lv)) conf_exp++;
        if (frc) frc_exp++;
        if (e_vld) rf_exp[e_idx] = e_data;
        if (e_sel == 2) void'(q.pop_front());
        if (lv && !full && li != 0 && e_sel != 3) q.push_back('{li, ld});
        sc = (!hadq || e_sel == 2) ? 0 : (sc < SM ? sc + 1 : SM);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 5'd4, 32'hdead, 1'b1, 5'd6, 32'hbeef);
        #1;
        chk("rst_wb_vld", 64'(bus.wb_rd_vld_o), 64'd0);
        chk("rst_wb_idx", 64'(bus.wb_rd_idx_o), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_rd_data_o), 64'd0);
        chk("rst_stall", 64'(bus.pipe_stall_o), 64'd0);
        chk("rst_rdy", 64'(bus.lu_rd_rdy_o), 64'd1);
        chk("rst_pend", 64'(bus.pend_mask_o), 64'd0);
        q.delete();
        sc = 0;
        conf_exp = '0;
        frc_exp = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf_exp[i] = '0;
            rf_dut[i] = '0;
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        @(negedge clk);
        do_reset();
        // Bypass from an idle queue.
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        chk("bypass_rf5", 64'(rf_exp[5]), 64'h1234);
        chk("bypass_pend", 64'(bus.pend_mask_o), 64'd0);
        // Pipe wins, LU queued, drained on the first idle cycle.
        step(1'b1, 5'd3, 32'haaaa, 1'b1, 5'd7, 32'hbbbb);
        chk("queued_pend7", 64'(bus.pend_mask_o[7]), 64'd1);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("drained_pend7", 64'(bus.pend_mask_o[7]), 64'd0);
        // Starvation: pipe busy every cycle with one queued LU result.
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd8, 32'h88);
        for (int i = 0; i < 6; i++) step(1'b1, 5'd1, 32'h100 + 32'(i), 1'b0, 5'd0, 32'h0);
        chk("starve_rf8", 64'(rf_exp[8]), 64'h88);
        // Fill the queue with a WAW pair on x9, third result held until space frees.
        step(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'h901);
        step(1'b1, 5'd2, 32'h23, 1'b1, 5'd9, 32'h902);
        chk("full_rdy", 64'(bus.lu_rd_rdy_o), 64'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, q.size() < QD ? 1'b0 : 1'b1, 5'd10, 32'ha03);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'ha03);
        chk("waw_rf9", 64'(rf_exp[9]), 64'h902);
        // x0 on both sources.
        step(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
        chk("x0_pend", 64'(bus.pend_mask_o), 64'd0);
        // Reset with two queued entries.
        step(1'b1, 5'd2, 32'h1, 1'b1, 5'd12, 32'hc1);
        step(1'b1, 5'd2, 32'h2, 1'b1, 5'd13, 32'hd1);
        do_reset();
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        // Random traffic with narrow index range to provoke WAW and x0.
        for (int n = 0; n < 3000; n++) begin
            if (n % 997 == 996) do_reset();
            step($urandom_range(0, 9) < 7, IDX_W'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, IDX_W'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), 64'(rf_dut[i]), 64'(rf_exp[i]));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
